// File: rtl/attn_score_value_mac_if.sv
// Bundle of the control handshake, job configuration and SRAM ports
// used by the S x V attention multiply-accumulate stage.
interface attn_score_value_mac_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
);
  logic              start;
  logic              ready;
  logic              done;
  logic [DIM_W-1:0]  n_rows;
  logic [DIM_W-1:0]  v_cols;
  logic [ADDR_W-1:0] s_base;
  logic [ADDR_W-1:0] v_base;
  logic [ADDR_W-1:0] z_base;
  logic [ADDR_W-1:0] s_rd_addr;
  logic [DATA_W-1:0] s_rd_data;
  logic [ADDR_W-1:0] v_rd_addr;
  logic [DATA_W-1:0] v_rd_data;
  logic              z_wr_en;
  logic [ADDR_W-1:0] z_wr_addr;
  logic [DATA_W-1:0] z_wr_data;

  modport slave (
    input  start, n_rows, v_cols, s_base, v_base, z_base, s_rd_data, v_rd_data,
    output ready, done, s_rd_addr, v_rd_addr, z_wr_en, z_wr_addr, z_wr_data
  );

  modport master (
    output start, n_rows, v_cols, s_base, v_base, z_base, s_rd_data, v_rd_data,
    input  ready, done, s_rd_addr, v_rd_addr, z_wr_en, z_wr_addr, z_wr_data
  );
endinterface

// File: rtl/attn_score_value_mac.sv
// Computes Z = S x V: streams one S/V read pair per cycle (i, j, k order),
// accumulates the returning products and writes each Z element on its last k.
module attn_score_value_mac #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DIM_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  attn_score_value_mac_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_next_s;

  logic [DIM_W-1:0]  n_r;
  logic [DIM_W-1:0]  d_r;
  logic [DIM_W-1:0]  i_r;
  logic [DIM_W-1:0]  j_r;
  logic [DIM_W-1:0]  k_r;
  logic [ADDR_W-1:0] s_addr_r;
  logic [ADDR_W-1:0] v_addr_r;
  logic [ADDR_W-1:0] s_row_r;
  logic [ADDR_W-1:0] v_col_r;
  logic [ADDR_W-1:0] v_base_r;
  logic [ADDR_W-1:0] z_ptr_r;
  logic [ADDR_W-1:0] n_ext_s;
  logic [ADDR_W-1:0] d_ext_s;

  logic [DATA_W-1:0] acc_r;
  logic [DATA_W-1:0] prod_s;
  logic [DATA_W-1:0] sum_s;
  logic              tag_valid_r;
  logic              tag_first_r;
  logic              tag_last_r;

  logic              accept_s;
  logic              zero_dim_s;
  logic              k_last_s;
  logic              j_last_s;
  logic              i_last_s;
  logic              last_pair_s;

  assign accept_s    = bus.start && ((state_r == IDLE) || (state_r == DONE));
  assign zero_dim_s  = (bus.n_rows == {DIM_W{1'b0}}) || (bus.v_cols == {DIM_W{1'b0}});
  assign k_last_s    = (k_r == (n_r - DIM_W'(1'b1)));
  assign j_last_s    = (j_r == (d_r - DIM_W'(1'b1)));
  assign i_last_s    = (i_r == (n_r - DIM_W'(1'b1)));
  assign last_pair_s = (state_r == RUN) && k_last_s && j_last_s && i_last_s;
  assign n_ext_s     = ADDR_W'(n_r);
  assign d_ext_s     = ADDR_W'(d_r);

  assign bus.ready     = (state_r == IDLE) || (state_r == DONE);
  assign bus.done      = (state_r == DONE);
  assign bus.s_rd_addr = s_addr_r;
  assign bus.v_rd_addr = v_addr_r;
  // Writes happen on the data-return cycle itself, so the strobe follows the delayed tag.
  assign bus.z_wr_en   = tag_valid_r && tag_last_r;
  assign bus.z_wr_addr = z_ptr_r;
  assign bus.z_wr_data = sum_s;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_next_s = zero_dim_s ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (last_pair_s) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN:   state_next_s = DONE;
      default: state_next_s = IDLE;
    endcase
  end

  // Loop counters and read-address generation; addresses hold outside RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_r      <= {DIM_W{1'b0}};
      d_r      <= {DIM_W{1'b0}};
      i_r      <= {DIM_W{1'b0}};
      j_r      <= {DIM_W{1'b0}};
      k_r      <= {DIM_W{1'b0}};
      s_addr_r <= {ADDR_W{1'b0}};
      v_addr_r <= {ADDR_W{1'b0}};
      s_row_r  <= {ADDR_W{1'b0}};
      v_col_r  <= {ADDR_W{1'b0}};
      v_base_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      n_r      <= bus.n_rows;
      d_r      <= bus.v_cols;
      i_r      <= {DIM_W{1'b0}};
      j_r      <= {DIM_W{1'b0}};
      k_r      <= {DIM_W{1'b0}};
      s_addr_r <= bus.s_base;
      v_addr_r <= bus.v_base;
      s_row_r  <= bus.s_base;
      v_col_r  <= bus.v_base;
      v_base_r <= bus.v_base;
    end else if ((state_r == RUN) && !last_pair_s) begin
      if (!k_last_s) begin
        k_r      <= k_r + DIM_W'(1'b1);
        s_addr_r <= s_addr_r + ADDR_W'(1'b1);
        v_addr_r <= v_addr_r + d_ext_s;
      end else if (!j_last_s) begin
        // Next column of V, same row of S.
        k_r      <= {DIM_W{1'b0}};
        j_r      <= j_r + DIM_W'(1'b1);
        s_addr_r <= s_row_r;
        v_col_r  <= v_col_r + ADDR_W'(1'b1);
        v_addr_r <= v_col_r + ADDR_W'(1'b1);
      end else begin
        k_r      <= {DIM_W{1'b0}};
        j_r      <= {DIM_W{1'b0}};
        i_r      <= i_r + DIM_W'(1'b1);
        s_row_r  <= s_row_r + n_ext_s;
        s_addr_r <= s_row_r + n_ext_s;
        v_col_r  <= v_base_r;
        v_addr_r <= v_base_r;
      end
    end
  end

  // One-cycle tag that travels alongside each outstanding read pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_valid_r <= 1'b0;
      tag_first_r <= 1'b0;
      tag_last_r  <= 1'b0;
    end else begin
      tag_valid_r <= (state_r == RUN);
      tag_first_r <= (k_r == {DIM_W{1'b0}});
      tag_last_r  <= k_last_s;
    end
  end

  // Products wrap modulo 2^DATA_W; the first k of each element restarts the sum.
  always_comb begin
    prod_s = bus.s_rd_data * bus.v_rd_data;
    if (tag_first_r) begin
      sum_s = prod_s;
    end else begin
      sum_s = acc_r + prod_s;
    end
  end

  // Accumulator and Z write pointer (Z is written strictly in row-major order).
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_r   <= {DATA_W{1'b0}};
      z_ptr_r <= {ADDR_W{1'b0}};
    end else begin
      if (tag_valid_r) begin
        acc_r <= tag_last_r ? {DATA_W{1'b0}} : sum_s;
      end
      if (accept_s) begin
        z_ptr_r <= bus.z_base;
      end else if (bus.z_wr_en) begin
        z_ptr_r <= z_ptr_r + ADDR_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_attn_score_value_mac.sv
// Self-checking bench for attn_score_value_mac: SRAM models, a matrix-product
// reference model with cycle-level expectations, directed and random jobs.
module tb_attn_score_value_mac;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int MW = 8;

  typedef struct {
    int          n;
    int          d;
    logic [15:0] sb;
    logic [15:0] vb;
    logic [15:0] zb;
  } cfg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  logic [31:0] mem_s [0:65535];
  logic [31:0] mem_v [0:65535];
  logic [31:0] zmem  [0:65535];

  always #5 clk = ~clk;

  attn_score_value_mac_if #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(MW)) bus ();

  attn_score_value_mac #(.ADDR_W(AW), .DATA_W(DW), .DIM_W(MW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Synchronous SRAMs: read data appears the cycle after the address.
  always @(posedge clk) begin
    bus.s_rd_data <= mem_s[bus.s_rd_addr];
    bus.v_rd_data <= mem_v[bus.v_rd_addr];
    if (bus.z_wr_en) zmem[bus.z_wr_addr] <= bus.z_wr_data;
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain matrix product, element reads wrap modulo 2^16.
  function automatic logic [31:0] ref_z(input cfg_t c, input int i, input int j);
    logic [31:0] acc;
    logic [15:0] a;
    logic [15:0] b;
    acc = 32'd0;
    for (int k = 0; k < c.n; k++) begin
      a = c.sb + 16'(i * c.n + k);
      b = c.vb + 16'(k * c.d + j);
      acc = acc + mem_s[a] * mem_v[b];
    end
    return acc;
  endfunction

  task automatic fill(input cfg_t c, input int mode);
    for (int x = 0; x < c.n * c.n; x++)
      mem_s[c.sb + 16'(x)] = (mode == 1) ? 32'hFFFF_FFFF : $urandom;
    for (int x = 0; x < c.n * c.d; x++)
      mem_v[c.vb + 16'(x)] = (mode == 1) ? 32'hFFFF_FFFF : $urandom;
  endtask

  task automatic launch(input cfg_t c, input bit now);
    if (!now) @(negedge clk);
    bus.start  = 1'b1;
    bus.n_rows = 8'(c.n);
    bus.v_cols = 8'(c.d);
    bus.s_base = c.sb;
    bus.v_base = c.vb;
    bus.z_base = c.zb;
  endtask

  // Follows one job cycle by cycle; cycle 0 is the accepting cycle.
  task automatic watch(input cfg_t c, input int mid, input int abort_at, input bit chain, input cfg_t nxt);
    int nnd;
    int t_done;
    int e;
    int r;
    bit exp_we;
    nnd    = c.n * c.n * c.d;
    t_done = (c.n == 0 || c.d == 0) ? 1 : nnd + 2;
    for (int cy = 1; cy <= t_done; cy++) begin
      @(negedge clk);
      check_val("done", 64'(bus.done), 64'(cy == t_done));
      check_val("ready", 64'(bus.ready), 64'(cy == t_done));
      exp_we = 1'b0;
      e = 0;
      if (c.n > 0 && c.d > 0 && cy >= c.n + 1 && ((cy - c.n - 1) % c.n) == 0) begin
        e = (cy - c.n - 1) / c.n;
        exp_we = (e < c.n * c.d);
      end
      check_val("z_wr_en", 64'(bus.z_wr_en), 64'(exp_we));
      if (exp_we) begin
        check_val("z_wr_addr", 64'(bus.z_wr_addr), 64'(c.zb + 16'(e)));
        check_val("z_wr_data", 64'(bus.z_wr_data), 64'(ref_z(c, e / c.d, e % c.d)));
      end
      if (cy <= nnd) begin
        r = cy - 1;
        check_val("s_rd_addr", 64'(bus.s_rd_addr),
                  64'(c.sb + 16'((r / (c.n * c.d)) * c.n + (r % c.n))));
        check_val("v_rd_addr", 64'(bus.v_rd_addr),
                  64'(c.vb + 16'((r % c.n) * c.d + ((r / c.n) % c.d))));
      end
      bus.start = 1'b0;
      if (cy == mid) begin
        bus.start  = 1'b1;
        bus.n_rows = 8'($urandom);
        bus.v_cols = 8'($urandom);
        bus.s_base = 16'($urandom);
        bus.v_base = 16'($urandom);
        bus.z_base = 16'($urandom);
      end
      if (cy == abort_at) begin
        reset = 1'b1;
        return;
      end
      if (cy == t_done && chain) launch(nxt, 1'b1);
    end
  endtask

  task automatic run_job(input cfg_t c);
    launch(c, 1'b0);
    watch(c, -1, -1, 1'b0, c);
  endtask

  cfg_t ca;
  cfg_t cb;

  initial begin
    bus.start  = 1'b0;
    bus.n_rows = 8'd0;
    bus.v_cols = 8'd0;
    bus.s_base = 16'd0;
    bus.v_base = 16'd0;
    bus.z_base = 16'd0;
    repeat (3) @(negedge clk);
    check_val("rst_ready", 64'(bus.ready), 64'd1);
    check_val("rst_done", 64'(bus.done), 64'd0);
    check_val("rst_we", 64'(bus.z_wr_en), 64'd0);
    check_val("rst_saddr", 64'(bus.s_rd_addr), 64'd0);
    check_val("rst_vaddr", 64'(bus.v_rd_addr), 64'd0);
    check_val("rst_zaddr", 64'(bus.z_wr_addr), 64'd0);
    reset = 1'b0;

    // 2x2 directed product.
    ca = '{n: 2, d: 2, sb: 16'h0010, vb: 16'h0020, zb: 16'h0040};
    mem_s[16'h10] = 32'd1; mem_s[16'h11] = 32'd2; mem_s[16'h12] = 32'd3; mem_s[16'h13] = 32'd4;
    mem_v[16'h20] = 32'd5; mem_v[16'h21] = 32'd6; mem_v[16'h22] = 32'd7; mem_v[16'h23] = 32'd8;
    run_job(ca);
    @(negedge clk);
    check_val("z2x2_0", 64'(zmem[16'h40]), 64'd19);
    check_val("z2x2_1", 64'(zmem[16'h41]), 64'd22);
    check_val("z2x2_2", 64'(zmem[16'h42]), 64'd43);
    check_val("z2x2_3", 64'(zmem[16'h43]), 64'd50);

    // N=1: a write follows every read.
    ca = '{n: 1, d: 3, sb: 16'h0100, vb: 16'h0200, zb: 16'h0300};
    mem_s[16'h100] = 32'd2;
    mem_v[16'h200] = 32'd1; mem_v[16'h201] = 32'd2; mem_v[16'h202] = 32'd3;
    run_job(ca);
    @(negedge clk);
    check_val("zn1_0", 64'(zmem[16'h300]), 64'd2);
    check_val("zn1_1", 64'(zmem[16'h301]), 64'd4);
    check_val("zn1_2", 64'(zmem[16'h302]), 64'd6);

    // Wrap-around accumulation.
    ca = '{n: 2, d: 2, sb: 16'h0400, vb: 16'h0500, zb: 16'h0600};
    fill(ca, 1);
    run_job(ca);
    @(negedge clk);
    for (int x = 0; x < 4; x++) check_val("zovf", 64'(zmem[16'h600 + 16'(x)]), 64'd2);

    // Zero-dimension jobs.
    ca = '{n: 0, d: 3, sb: 16'h0000, vb: 16'h0000, zb: 16'h0700};
    run_job(ca);
    ca = '{n: 3, d: 0, sb: 16'h0000, vb: 16'h0000, zb: 16'h0700};
    run_job(ca);

    // Mid-job start ignored, DONE-cycle start chains a second job.
    ca = '{n: 2, d: 3, sb: 16'h0800, vb: 16'h0900, zb: 16'h0A00};
    cb = '{n: 3, d: 2, sb: 16'h0B00, vb: 16'h0C00, zb: 16'h0D00};
    fill(ca, 0);
    fill(cb, 0);
    launch(ca, 1'b0);
    watch(ca, 5, -1, 1'b1, cb);
    watch(cb, -1, -1, 1'b0, cb);

    // Reset in the middle of a 3x3x3 job.
    ca = '{n: 3, d: 3, sb: 16'h0E00, vb: 16'h0F00, zb: 16'h1000};
    fill(ca, 0);
    launch(ca, 1'b0);
    watch(ca, -1, 4, 1'b0, ca);
    @(negedge clk);
    check_val("abort_ready", 64'(bus.ready), 64'd1);
    check_val("abort_done", 64'(bus.done), 64'd0);
    check_val("abort_we", 64'(bus.z_wr_en), 64'd0);
    reset = 1'b0;
    for (int x = 0; x < 20; x++) begin
      @(negedge clk);
      check_val("abort_quiet", 64'(bus.z_wr_en), 64'd0);
    end
    run_job(ca);

    // Random jobs, bases may wrap past the top of the address space.
    for (int t = 0; t < 10; t++) begin
      ca.n  = int'($urandom_range(1, 4));
      ca.d  = int'($urandom_range(1, 4));
      ca.sb = 16'($urandom);
      ca.vb = 16'($urandom);
      ca.zb = 16'($urandom);
      fill(ca, 0);
      run_job(ca);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
